maze_top: RTL and testbench

Top level of a single-player FPGA maze game. Four active-low direction keys move a player token cell by cell through a fixed 8×6 maze. The block renders the maze on a 640×480@60 Hz VGA DAC interface and shows the successful-move count in decimal on three 7-segment displays. Player position and game state appear on LEDs.

---
 rtl/maze_pkg.sv | 30 +++
 rtl/vga_timing.sv | 36 +++
 rtl/maze_top.sv | 120 ++++++++++++
 tb/tb_maze_top.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// maze_pkg: maze map, VGA timing, colours and 7-segment decode shared by the maze game
package maze_pkg;
  typedef enum logic {PLAYING, WON} game_state_t;
  localparam logic [5:0][7:0] MAZE_ROWS = {8'h00, 8'hEE, 8'h08, 8'h73, 8'h18, 8'h42};
  localparam logic [2:0] START_X = 3'd0;
  localparam logic [2:0] START_Y = 3'd0;
  localparam logic [2:0] GOAL_X = 3'd7;
  localparam logic [2:0] GOAL_Y = 3'd5;
  localparam int H_VISIBLE = 640;
  localparam int H_SYNC_START = 656;
  localparam int H_SYNC_END = 752;
  localparam int H_TOTAL = 800;
  localparam int V_VISIBLE = 480;
  localparam int V_SYNC_START = 490;
  localparam int V_SYNC_END = 492;
  localparam int V_TOTAL = 525;
  localparam logic [23:0] COL_BLACK = 24'h000000;
  localparam logic [23:0] COL_PLAYER = 24'hFF0000;
  localparam logic [23:0] COL_GOAL = 24'h00FF00;
  localparam logic [23:0] COL_WIN = 24'hFFFF00;
  localparam logic [23:0] COL_WALL = 24'h808080;
  localparam logic [9:0][6:0] SEG_LUT = {7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
                                         7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
  function automatic logic [6:0] seg7(input logic [3:0] d);
    return d > 4'd9 ? 7'h7F : SEG_LUT[d];
  endfunction
  function automatic logic is_wall(input logic [2:0] x, input logic [2:0] y);
    return y > 3'd5 ? 1'b1 : MAZE_ROWS[y][x];
  endfunction
endpackage

// File: rtl/vga_timing.sv
// vga_timing: 25 MHz pixel enable, 640x480@60 counters, registered syncs and blank
module vga_timing
  import maze_pkg::*;
(
  input  logic       Clk,
  input  logic       Rst,
  output logic       pix_en,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       hsync,
  output logic       vsync,
  output logic       blank
);
  logic h_end, v_end;
  assign h_end = hcount == 10'(H_TOTAL - 1);
  assign v_end = vcount == 10'(V_TOTAL - 1);
  // enable toggles every clock; counters, syncs and blank move on its high phase
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      pix_en <= 1'b0;
      hcount <= '0;
      vcount <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
      blank <= 1'b0;
    end else begin
      pix_en <= ~pix_en;
      if (pix_en) begin
        hcount <= h_end ? '0 : hcount + 10'd1;
        vcount <= h_end ? (v_end ? '0 : vcount + 10'd1) : vcount;
        hsync <= !(hcount >= 10'(H_SYNC_START) && hcount < 10'(H_SYNC_END));
        vsync <= !(vcount >= 10'(V_SYNC_START) && vcount < 10'(V_SYNC_END));
        blank <= hcount < 10'(H_VISIBLE) && vcount < 10'(V_VISIBLE);
      end
    end
endmodule

// File: rtl/maze_top.sv
// maze_top: key-driven maze game with VGA rendering, BCD move counter and status LEDs
module maze_top
  import maze_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CELL_PX = 80
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [3:0] Keyboard,
  output logic [6:0] o_FND0,
  output logic [6:0] o_FND1,
  output logic [6:0] o_FND2,
  output logic [7:0] o_Red,
  output logic [7:0] o_Green,
  output logic [7:0] o_Blue,
  output logic       o_Clk,
  output logic       o_blank,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic [1:0] o_LED0,
  output logic [3:0] o_LED1,
  output logic [3:0] o_LED2
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [3:0] key_meta, key_sync, key_cur, key_prev, pressed, tx, ty;
  logic [CW-1:0] tick_cnt;
  logic tick, sample_stb, accept, legal;
  logic [2:0] px, py;
  logic [3:0] d0, d1, d2;
  game_state_t state;
  logic pix_en, visible, in_maze, hit_player, hit_goal, hit_wall;
  logic [9:0] hcount, vcount, cell_x, cell_y;
  logic [23:0] colour, rgb;
  vga_timing u_vga (
    .Clk(Clk),
    .Rst(Rst),
    .pix_en(pix_en),
    .hcount(hcount),
    .vcount(vcount),
    .hsync(o_hsync),
    .vsync(o_vsync),
    .blank(o_blank)
  );
  assign o_Clk = pix_en;
  assign tick = tick_cnt == CW'(DEBOUNCE_CYCLES - 1);
  // synchronize keys and take a sample every debounce period; prev resets low so a held key needs a release
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      key_meta <= '0;
      key_sync <= '0;
      key_cur <= '0;
      key_prev <= '0;
      tick_cnt <= '0;
      sample_stb <= 1'b0;
    end else begin
      key_meta <= Keyboard;
      key_sync <= key_meta;
      tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
      sample_stb <= tick;
      key_cur <= tick ? key_sync : key_cur;
      key_prev <= tick ? key_cur : key_prev;
    end
  assign pressed = ~key_cur;
  assign accept = sample_stb && state == PLAYING && key_prev == 4'hF && $onehot(pressed);
  assign tx = pressed[0] ? {1'b0, px} + 4'd1 : pressed[2] ? {1'b0, px} - 4'd1 : {1'b0, px};
  assign ty = pressed[1] ? {1'b0, py} + 4'd1 : pressed[3] ? {1'b0, py} - 4'd1 : {1'b0, py};
  assign legal = tx < 4'd8 && ty < 4'd6 && !is_wall(tx[2:0], ty[2:0]);
  // game FSM: move on a legal press, count moves in BCD saturating at 999, latch win at the goal
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      state <= PLAYING;
      px <= START_X;
      py <= START_Y;
      d0 <= '0;
      d1 <= '0;
      d2 <= '0;
    end else if (accept && legal) begin
      px <= tx[2:0];
      py <= ty[2:0];
      state <= (tx[2:0] == GOAL_X && ty[2:0] == GOAL_Y) ? WON : state;
      if (!(d2 == 4'd9 && d1 == 4'd9 && d0 == 4'd9)) begin
        d0 <= d0 == 4'd9 ? 4'd0 : d0 + 4'd1;
        d1 <= d0 == 4'd9 ? (d1 == 4'd9 ? 4'd0 : d1 + 4'd1) : d1;
        d2 <= (d0 == 4'd9 && d1 == 4'd9) ? d2 + 4'd1 : d2;
      end
    end
  // displays and LEDs follow the game state one clock later
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      o_FND0 <= 7'b1000000;
      o_FND1 <= 7'b1000000;
      o_FND2 <= 7'b1000000;
      o_LED0 <= 2'b01;
      o_LED1 <= '0;
      o_LED2 <= '0;
    end else begin
      o_FND0 <= seg7(d0);
      o_FND1 <= seg7(d1);
      o_FND2 <= seg7(d2);
      o_LED0 <= {state == WON, state == PLAYING};
      o_LED1 <= {1'b0, px};
      o_LED2 <= {1'b0, py};
    end
  assign cell_x = hcount / 10'(CELL_PX);
  assign cell_y = vcount / 10'(CELL_PX);
  assign visible = hcount < 10'(H_VISIBLE) && vcount < 10'(V_VISIBLE);
  assign in_maze = cell_x < 10'd8 && cell_y < 10'd6;
  assign hit_player = cell_x == 10'(px) && cell_y == 10'(py);
  assign hit_goal = cell_x == 10'(GOAL_X) && cell_y == 10'(GOAL_Y);
  assign hit_wall = in_maze && is_wall(cell_x[2:0], cell_y[2:0]);
  assign colour = !visible ? COL_BLACK :
                  (hit_player || hit_goal) ? (state == WON ? COL_WIN : hit_player ? COL_PLAYER : COL_GOAL) :
                  hit_wall ? COL_WALL : COL_BLACK;
  // pixel colour registered on the same enable as the syncs to keep them aligned
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) rgb <= '0;
    else if (pix_en) rgb <= colour;
  assign {o_Red, o_Green, o_Blue} = rgb;
endmodule

// File: tb/tb_maze_top.sv
// tb_maze_top: scoreboard bench for the maze game with a grid-level reference model
module tb_maze_top;
  localparam int DEB = 4;
  localparam int CELL = 8;
  localparam int HOLD = 16;
  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic [3:0] Keyboard = 4'hF;
  logic [6:0] o_FND0, o_FND1, o_FND2;
  logic [7:0] o_Red, o_Green, o_Blue;
  logic o_Clk, o_blank, o_hsync, o_vsync;
  logic [1:0] o_LED0;
  logic [3:0] o_LED1, o_LED2;

  maze_top #(.DEBOUNCE_CYCLES(DEB), .CELL_PX(CELL)) dut (
    .Clk(Clk), .Rst(Rst), .Keyboard(Keyboard),
    .o_FND0(o_FND0), .o_FND1(o_FND1), .o_FND2(o_FND2),
    .o_Red(o_Red), .o_Green(o_Green), .o_Blue(o_Blue),
    .o_Clk(o_Clk), .o_blank(o_blank), .o_hsync(o_hsync), .o_vsync(o_vsync),
    .o_LED0(o_LED0), .o_LED1(o_LED1), .o_LED2(o_LED2)
  );

  always #10 Clk = ~Clk;

  typedef struct {int x; int y; int cnt; bit win;} exp_t;
  exp_t sbq[$];
  int n_chk = 0;
  int n_pass = 0;
  int unsigned cyc = 0;
  int mx, my, mcnt;
  bit mwin;
  logic [3:0] mprev;
  logic [7:0] maze_rows [6] = '{8'h42, 8'h18, 8'h73, 8'h08, 8'hEE, 8'h00};
  logic [6:0] seg_ref [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [3:0] path [18] = '{4'hD, 4'hF, 4'hE, 4'hF, 4'hE, 4'hF, 4'hD, 4'hF, 4'hD,
                            4'hF, 4'hB, 4'hF, 4'hB, 4'hF, 4'hD, 4'hF, 4'hD, 4'hF};
  logic [3:0] directed [16] = '{4'hF, 4'h7, 4'hF, 4'hE, 4'hF, 4'hD, 4'hF, 4'hE,
                                4'hF, 4'hE, 4'hF, 4'hD, 4'hF, 4'hC, 4'hF, 4'h3};

  always @(posedge Clk or negedge Rst)
    if (!Rst) cyc <= 0;
    else cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic void model(input logic [3:0] pat);
    int nx, ny;
    logic [3:0] low;
    low = ~pat;
    if (!mwin && mprev == 4'hF && $countones(low) == 1) begin
      nx = mx + (low[0] ? 1 : 0) - (low[2] ? 1 : 0);
      ny = my + (low[1] ? 1 : 0) - (low[3] ? 1 : 0);
      if (nx >= 0 && nx < 8 && ny >= 0 && ny < 6 && !maze_rows[ny][nx]) begin
        mx = nx;
        my = ny;
        if (mcnt < 999) mcnt++;
        if (mx == 7 && my == 5) mwin = 1;
      end
    end
    mprev = pat;
  endfunction

  task automatic step(input logic [3:0] pat, input int hold = HOLD);
    exp_t e;
    Keyboard = pat;
    repeat (hold) @(negedge Clk);
    model(pat);
    e = '{mx, my, mcnt, mwin};
    sbq.push_back(e);
  endtask

  always @(negedge Clk)
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      check("led1_x", o_LED1, e.x);
      check("led2_y", o_LED2, e.y);
      check("led0_state", o_LED0, {e.win, ~e.win});
      check("fnd0", o_FND0, seg_ref[e.cnt % 10]);
      check("fnd1", o_FND1, seg_ref[(e.cnt / 10) % 10]);
      check("fnd2", o_FND2, seg_ref[e.cnt / 100]);
    end

  task automatic reset_dut(input logic [3:0] kr);
    repeat (2) @(negedge Clk);
    Keyboard = kr;
    Rst = 1'b0;
    #1;
    check("rst_led0", o_LED0, 2'b01);
    check("rst_led1", o_LED1, 0);
    check("rst_led2", o_LED2, 0);
    check("rst_fnd0", o_FND0, 7'b1000000);
    check("rst_fnd1", o_FND1, 7'b1000000);
    check("rst_fnd2", o_FND2, 7'b1000000);
    check("rst_hsync", o_hsync, 1);
    check("rst_vsync", o_vsync, 1);
    check("rst_blank", o_blank, 0);
    check("rst_rgb", {o_Red, o_Green, o_Blue}, 0);
    check("rst_oclk", o_Clk, 0);
    repeat (3) @(negedge Clk);
    mx = 0; my = 0; mcnt = 0; mwin = 0; mprev = 4'h0;
    Rst = 1'b1;
  endtask

  task automatic chk_pix(input int h, input int v, input logic [23:0] rgb, input logic blk);
    int unsigned at;
    at = 2 * (v * 800 + h) + 2;
    while (cyc < at) @(negedge Clk);
    check($sformatf("rgb_%0d_%0d", h, v), {o_Red, o_Green, o_Blue}, rgb);
    check($sformatf("blank_%0d_%0d", h, v), o_blank, blk);
  endtask

  task automatic wait_hsync(input logic lvl);
    int k;
    k = 0;
    while (o_hsync !== lvl && k < 4000) begin
      @(negedge Clk);
      k++;
    end
  endtask

  task automatic meas_hsync;
    int unsigned t0, t1, t2;
    wait_hsync(1'b1);
    wait_hsync(1'b0);
    t0 = cyc;
    wait_hsync(1'b1);
    t1 = cyc;
    wait_hsync(1'b0);
    t2 = cyc;
    check("hsync_low_clks", t1 - t0, 192);
    check("line_period_clks", t2 - t0, 1600);
  endtask

  initial begin
    reset_dut(4'hF);
    fork
      begin
        step(4'hF);
        foreach (path[i]) step(path[i]);
        for (int i = 0; i < 7; i++) begin
          step(4'hE);
          step(4'hF);
        end
        step(4'hD);
        step(4'hF);
        step(4'hB);
        step(4'hF);
      end
      begin
        chk_pix(3, 0, 24'hFF0000, 1'b1);
        chk_pix(11, 0, 24'h808080, 1'b1);
        chk_pix(20, 0, 24'h000000, 1'b1);
        chk_pix(100, 0, 24'h000000, 1'b1);
        chk_pix(700, 0, 24'h000000, 1'b0);
        chk_pix(3, 7, 24'h000000, 1'b1);
        chk_pix(3, 16, 24'h808080, 1'b1);
        chk_pix(59, 32, 24'h808080, 1'b1);
        chk_pix(51, 40, 24'h000000, 1'b1);
        chk_pix(59, 40, 24'hFFFF00, 1'b1);
      end
    join
    meas_hsync();
    reset_dut(4'hE);
    step(4'hE);
    foreach (directed[i]) begin
      if (i == 11) step(directed[i], 200);
      else step(directed[i]);
    end
    step(4'hF);
    for (int i = 0; i < 150; i++) begin
      int r;
      logic [3:0] p;
      r = $urandom_range(0, 9);
      p = r < 4 ? 4'hF :
          r < 8 ? ~(4'b0001 << $urandom_range(0, 3)) :
          r == 8 ? ~(4'b0011 << $urandom_range(0, 2)) : 4'($urandom_range(0, 15));
      step(p);
    end
    for (int k = 0; k < 10 && sbq.size() > 0; k++) @(negedge Clk);
    if (sbq.size() > 0) check("scoreboard_drain", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
